// File: rtl/if_pkg.sv
// Shared definitions for the IF scratchpad window reader: FSM encodings and ring-offset helper.
package if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_READ   = 3'd3,
    ST_DONE   = 3'd4,
    ST_RELOAD = 3'd5
  } state_e;

  // Distance from ring origin b forward to address a, for a ring of 'depth' entries.
  function automatic logic [31:0] ring_off(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] depth);
    return (a + depth - b) % depth;
  endfunction

endpackage

// File: rtl/if_ring_addr_gen.sv
// Ring address generator: element address, base offset from row start and window-fits flag.
module if_ring_addr_gen
  import if_pkg::*;
#(
  parameter int ADDR_LEN      = 8,
  parameter int SCRATCH_DEPTH = 16,
  parameter int FILT_LEN      = 4
) (
  input  logic [ADDR_LEN-1:0] base_i,
  input  logic [ADDR_LEN-1:0] idx_i,
  input  logic [ADDR_LEN-1:0] start_if_i,
  input  logic [ADDR_LEN-1:0] end_if_i,
  input  logic [ADDR_LEN-1:0] waddr_i,
  input  logic                end_valid_i,
  output logic [ADDR_LEN-1:0] addr_o,
  output logic                fits_o
);

  localparam int AW1 = ADDR_LEN + 1;

  logic [AW1-1:0] sum;
  logic [AW1-1:0] off_base;
  logic [AW1-1:0] off_end;
  logic [AW1-1:0] off_waddr;
  logic [AW1-1:0] avail;
  logic [AW1-1:0] need;

  assign sum    = {1'b0, base_i} + {1'b0, idx_i};
  assign addr_o = ADDR_LEN'(sum % AW1'(SCRATCH_DEPTH));

  assign off_base  = AW1'(ring_off(32'(base_i),  32'(start_if_i), 32'(SCRATCH_DEPTH)));
  assign off_end   = AW1'(ring_off(32'(end_if_i), 32'(start_if_i), 32'(SCRATCH_DEPTH)));
  assign off_waddr = AW1'(ring_off(32'(waddr_i),  32'(start_if_i), 32'(SCRATCH_DEPTH)));

  // A bounded row holds off(end)+1 elements, so a full ring counts as DEPTH.
  assign avail  = end_valid_i ? (off_end + AW1'(1)) : off_waddr;
  assign need   = off_base + AW1'(FILT_LEN);
  assign fits_o = (need <= avail);

endmodule

// File: rtl/if_window_reader.sv
// Sliding-window reader over the IF scratchpad ring with valid/ready output.
// Define IF_WINDOW_READER_PERF_EN to add the stall_cnt performance counter output.
module if_window_reader
  import if_pkg::*;
#(
  parameter int ADDR_LEN      = 8,
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 16,
  parameter int FILT_LEN      = 4,
  parameter int STRIDE        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_LEN-1:0]      start_IF,
  input  logic [ADDR_LEN-1:0]      end_IF,
  input  logic                     IF_end_valid,
  input  logic [ADDR_LEN-1:0]      IF_waddr,
  output logic                     scratch_ren,
  output logic [ADDR_LEN-1:0]      scratch_raddr,
  input  logic [SCRATCH_WIDTH-1:0] scratch_rdata,
  output logic [SCRATCH_WIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     full_done,
  output logic                     busy
`ifdef IF_WINDOW_READER_PERF_EN
  ,output logic [15:0]             stall_cnt
`endif
);

  localparam int AW1 = ADDR_LEN + 1;

  state_e                   state_q, state_d;
  logic [ADDR_LEN-1:0]      base_q, base_d;
  logic [ADDR_LEN-1:0]      idx_q, idx_d;
  logic                     inflight_q, inflight_d;
  logic [SCRATCH_WIDTH-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;

  logic [ADDR_LEN-1:0] addr;
  logic                fits;
  logic                issue;
  logic                accept;
  logic                last_accept;
  logic [AW1-1:0]      base_step;

  if_ring_addr_gen #(
    .ADDR_LEN      (ADDR_LEN),
    .SCRATCH_DEPTH (SCRATCH_DEPTH),
    .FILT_LEN      (FILT_LEN)
  ) u_addr_gen (
    .base_i      (base_q),
    .idx_i       (idx_q),
    .start_if_i  (start_IF),
    .end_if_i    (end_IF),
    .waddr_i     (IF_waddr),
    .end_valid_i (IF_end_valid),
    .addr_o      (addr),
    .fits_o      (fits)
  );

  // Once the window's last element is captured, no more reads until it is accepted.
  assign issue = (state_q == ST_READ) && !start && !inflight_q &&
                 !(out_valid_q && out_last_q) && (!out_valid_q || out_ready);
  assign accept      = out_valid_q && out_ready;
  assign last_accept = (state_q == ST_READ) && accept && out_last_q;
  assign base_step   = {1'b0, base_q} + AW1'(STRIDE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      inflight_q  <= inflight_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_LOAD:   state_d = ST_CHECK;
      ST_CHECK: begin
        if (IF_end_valid && !fits) state_d = ST_DONE;
        else if (fits)             state_d = ST_READ;
      end
      ST_READ:   if (last_accept) state_d = ST_CHECK;
      ST_DONE:   state_d = ST_RELOAD;
      ST_RELOAD: state_d = ST_LOAD;
      default:   state_d = ST_IDLE;
    endcase
    if (start) state_d = ST_LOAD;
  end

  always_comb begin
    base_d      = base_q;
    idx_d       = idx_q;
    inflight_d  = inflight_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q && !out_ready;
    if (state_q == ST_LOAD) begin
      base_d = start_IF;
      idx_d  = '0;
    end
    if (issue) inflight_d = 1'b1;
    // Read data arrives the cycle after issue; idx holds on the last element.
    if (inflight_q) begin
      inflight_d  = 1'b0;
      out_data_d  = scratch_rdata;
      out_valid_d = 1'b1;
      out_last_d  = (idx_q == ADDR_LEN'(FILT_LEN - 1));
      if (idx_q != ADDR_LEN'(FILT_LEN - 1)) idx_d = idx_q + ADDR_LEN'(1);
    end
    if (last_accept) begin
      base_d = ADDR_LEN'(base_step % AW1'(SCRATCH_DEPTH));
      idx_d  = '0;
    end
    if (start) begin
      inflight_d  = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_comb begin
    scratch_ren   = issue;
    scratch_raddr = addr;
    out_data      = out_data_q;
    out_valid     = out_valid_q;
    out_last      = out_last_q;
    full_done     = (state_q == ST_DONE);
    busy          = (state_q != ST_IDLE);
  end

`ifdef IF_WINDOW_READER_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_CHECK) && !fits && !IF_end_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_window_reader.sv
// Directed self-checking bench for if_window_reader (DEPTH=16, FILT_LEN=4, STRIDE=1).
module tb_if_window_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  start_IF;
  logic [7:0]  end_IF;
  logic        IF_end_valid;
  logic [7:0]  IF_waddr;
  logic        scratch_ren;
  logic [7:0]  scratch_raddr;
  logic [15:0] scratch_rdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        full_done;
  logic        busy;
`ifdef IF_WINDOW_READER_PERF_EN
  logic [15:0] stall_cnt;
`endif

  if_window_reader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_IF      (start_IF),
    .end_IF        (end_IF),
    .IF_end_valid  (IF_end_valid),
    .IF_waddr      (IF_waddr),
    .scratch_ren   (scratch_ren),
    .scratch_raddr (scratch_raddr),
    .scratch_rdata (scratch_rdata),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .full_done     (full_done),
    .busy          (busy)
`ifdef IF_WINDOW_READER_PERF_EN
    ,.stall_cnt    (stall_cnt)
`endif
  );

  int checks = 0;
  int passes = 0;

  logic [15:0] mem [256];
  logic [15:0] acc_data [$];
  bit          acc_last [$];
  logic [7:0]  ren_addr [$];
  int          done_cnt = 0;

  int exp_t1 [16] = '{0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,6};
  int exp_t3 [12] = '{14,15,0,1, 15,0,1,2, 0,1,2,3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scratchpad model: registered read, data = 0xA000 + address.
  always @(posedge clk) if (scratch_ren) scratch_rdata <= mem[scratch_raddr];

  // Inputs change only at posedge+1, so negedge samples match what the next edge sees.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        acc_data.push_back(out_data);
        acc_last.push_back(out_last);
      end
      if (scratch_ren) ren_addr.push_back(scratch_raddr);
      if (full_done) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_data.delete();
    acc_last.delete();
    ren_addr.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (full_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int first;
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    rst = 1'b0; start = 1'b0; start_IF = '0; end_IF = '0;
    IF_end_valid = 1'b0; IF_waddr = '0; out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_raddr", 32'(scratch_raddr), 32'd0);
    check("rst_ren_done", 32'({scratch_ren, full_done, out_last}), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: writer streaming, row not ended
    start_IF = 8'd0; IF_waddr = 8'd6; IF_end_valid = 1'b0;
    clear_mon();
    pulse_start();
    repeat (60) tick();
    check("t1_count", 32'(acc_data.size()), 32'd12);
    for (int i = 0; i < 12 && i < acc_data.size(); i++) begin
      check($sformatf("t1_data%0d", i), 32'(acc_data[i]), 32'hA000 + 32'(exp_t1[i]));
      check($sformatf("t1_last%0d", i), 32'(acc_last[i]), 32'((i % 4) == 3));
    end
    check("t1_stall_busy", 32'(busy), 32'd1);
    check("t1_stall_reads", 32'(ren_addr.size()), 32'd12);
    IF_waddr = 8'd7;
    repeat (20) tick();
    check("t1_resume_count", 32'(acc_data.size()), 32'd16);
    for (int i = 12; i < 16 && i < acc_data.size(); i++)
      check($sformatf("t1_data%0d", i), 32'(acc_data[i]), 32'hA000 + 32'(exp_t1[i]));

    // 2: bounded row 0..5
    start_IF = 8'd0; end_IF = 8'd5; IF_end_valid = 1'b1;
    clear_mon();
    pulse_start();
    wait_done("t2_done_seen");
    IF_end_valid = 1'b0; IF_waddr = start_IF;
    repeat (20) tick();
    check("t2_count", 32'(acc_data.size()), 32'd12);
    for (int i = 0; i < 12 && i < acc_data.size(); i++)
      check($sformatf("t2_data%0d", i), 32'(acc_data[i]), 32'hA000 + 32'(exp_t1[i]));
    check("t2_reads", 32'(ren_addr.size()), 32'd12);
    check("t2_done_pulses", 32'(done_cnt), 32'd1);

    // 3: row wrapping around the ring
    start_IF = 8'd14; end_IF = 8'd3; IF_end_valid = 1'b1;
    clear_mon();
    pulse_start();
    wait_done("t3_done_seen");
    IF_end_valid = 1'b0; IF_waddr = start_IF;
    repeat (20) tick();
    check("t3_reads", 32'(ren_addr.size()), 32'd12);
    for (int i = 0; i < 12 && i < ren_addr.size(); i++)
      check($sformatf("t3_addr%0d", i), 32'(ren_addr[i]), 32'(exp_t3[i]));
    for (int i = 0; i < 12 && i < acc_data.size(); i++)
      check($sformatf("t3_data%0d", i), 32'(acc_data[i]), 32'hA000 + 32'(exp_t3[i]));
    check("t3_done_pulses", 32'(done_cnt), 32'd1);

    // 5: short row, no window fits
    start_IF = 8'd4; end_IF = 8'd5; IF_end_valid = 1'b1;
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (full_done && first < 0) begin
        first = k;
        IF_end_valid = 1'b0; IF_waddr = start_IF;
      end
    end
    check("t5_done_cycle", 32'(first), 32'd2);
    repeat (10) tick();
    check("t5_reads", 32'(ren_addr.size()), 32'd0);
    check("t5_done_pulses", 32'(done_cnt), 32'd1);

    // 4: backpressure mid-window
    start_IF = 8'd0; IF_waddr = 8'd8; IF_end_valid = 1'b0;
    clear_mon();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (acc_data.size() == 2 && out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("t4_reach", 32'(seen), 32'd1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t4_hold_valid%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("t4_hold_data%0d", c), 32'(out_data), 32'hA002);
      check($sformatf("t4_hold_ren%0d", c), 32'({scratch_ren, out_last}), 32'd0);
    end
    tick();
    out_ready = 1'b1;
    repeat (80) tick();
    check("t4_count", 32'(acc_data.size()), 32'd20);
    check("t4_reads", 32'(ren_addr.size()), 32'd20);
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < 4; i++)
        if (b * 4 + i < acc_data.size())
          check($sformatf("t4_data%0d", b * 4 + i), 32'(acc_data[b * 4 + i]), 32'hA000 + 32'(b + i));

    // 6: asynchronous reset during READ
    start_IF = 8'd0; IF_waddr = 8'd6; IF_end_valid = 1'b0;
    clear_mon();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("t6_reach", 32'(seen), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data", 32'(out_data), 32'd0);
    check("t6_raddr", 32'(scratch_raddr), 32'd0);
    check("t6_ren_done_last", 32'({scratch_ren, full_done, out_last}), 32'd0);
    tick(); tick();
    #2 rst = 1'b1;
    clear_mon();
    repeat (10) tick();
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_reads", 32'(ren_addr.size()), 32'd0);
    pulse_start();
    repeat (60) tick();
    check("t6_restart_count", 32'(acc_data.size()), 32'd12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
